// File: rtl/k_lpf_multichannel.sv
// Time-multiplexed first-order IIR low-pass filter shared across NCH channels.
// Two stages: S0 captures the sample, S1 filters it and writes channel state and output.
module k_lpf_multichannel #(
  parameter int unsigned             DW    = 16,
  parameter int unsigned             FB    = 32,
  parameter int unsigned             NCH   = 8,
  parameter logic signed [DW-1:0]    INIT  = 16'sd8192,
  parameter int unsigned             K_MAX = 31,
  localparam int unsigned            AW    = DW + FB,
  localparam int unsigned            CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic signed [DW-1:0] x_in,
  input  logic                 x_valid,
  input  logic [CW-1:0]        x_chan,
  input  logic [4:0]           k_sel,
  input  logic                 bypass,
  input  logic                 preload,
  output logic signed [DW-1:0] y_out,
  output logic                 y_valid,
  output logic [CW-1:0]        y_chan
);

  localparam int unsigned KW    = 5;
  localparam int unsigned NSLOT = 1 << CW;

  typedef logic [(2**KW)-1:0][KW-1:0] k_lut_t;

  // Legal-range clamp of k_sel, precomputed so no runtime compare is needed
  function automatic k_lut_t build_k_lut();
    k_lut_t lut;
    for (int unsigned i = 0; i < 2**KW; i++) begin
      if (i == 0)         lut[i] = KW'(1);
      else if (i > K_MAX) lut[i] = KW'(K_MAX);
      else                lut[i] = KW'(i);
    end
    return lut;
  endfunction

  function automatic logic [NSLOT-1:0] build_chan_ok();
    logic [NSLOT-1:0] ok;
    for (int unsigned i = 0; i < NSLOT; i++) ok[i] = (i < NCH);
    return ok;
  endfunction

  localparam k_lut_t            K_LUT   = build_k_lut();
  localparam logic [NSLOT-1:0]  CHAN_OK = build_chan_ok();

  localparam logic signed [AW:0] INIT_ST = {INIT[DW-1], INIT, {FB{1'b0}}};
  localparam logic signed [AW:0] Y_MAX   = {{(FB+1){1'b0}}, 1'b0, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] Y_MIN   = {{(FB+1){1'b1}}, 1'b1, {(DW-1){1'b0}}};

  // S0 pipeline registers
  logic signed [DW-1:0] x_q, x_d;
  logic [CW-1:0]        chan_q, chan_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 bypass_q, bypass_d;
  logic                 preload_q, preload_d;
  logic                 acc_q, acc_d;

  // Per-channel filter state
  logic signed [AW:0]   xp_q [NCH];
  logic signed [AW:0]   xp_d [NCH];
  logic signed [AW:0]   y_q  [NCH];
  logic signed [AW:0]   y_d  [NCH];

  logic signed [DW-1:0] y_out_q, y_out_d;
  logic                 y_valid_q, y_valid_d;
  logic [CW-1:0]        y_chan_q, y_chan_d;

  logic signed [AW:0]   x_ext, xp_cur, y_cur, s_sum, y_new, y_int;
  logic signed [DW-1:0] y_sat;

  // S0: capture only accepted samples, otherwise hold
  always_comb begin
    acc_d     = x_valid & enable & CHAN_OK[x_chan];
    x_d       = x_q;
    chan_d    = chan_q;
    k_d       = k_q;
    bypass_d  = bypass_q;
    preload_d = preload_q;
    if (acc_d) begin
      x_d       = x_in;
      chan_d    = x_chan;
      k_d       = K_LUT[k_sel];
      bypass_d  = bypass;
      preload_d = preload;
    end
  end

  // S1: filter arithmetic; steady state y == x makes the two shifted terms cancel
  always_comb begin
    x_ext  = {x_q[DW-1], x_q, {FB{1'b0}}};
    xp_cur = xp_q[chan_q];
    y_cur  = y_q[chan_q];
    s_sum  = x_ext + xp_cur;
    y_new  = y_cur + (s_sum >>> k_q) - (y_cur >>> (k_q - KW'(1)));
    y_int  = y_new >>> FB;
    if (y_int > Y_MAX)      y_sat = {1'b0, {(DW-1){1'b1}}};
    else if (y_int < Y_MIN) y_sat = {1'b1, {(DW-1){1'b0}}};
    else                    y_sat = y_new[AW-1:FB];
  end

  // S1: state write-back and output selection
  always_comb begin
    xp_d      = xp_q;
    y_d       = y_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    y_chan_d  = y_chan_q;
    if (acc_q) begin
      y_valid_d    = 1'b1;
      y_chan_d     = chan_q;
      xp_d[chan_q] = x_ext;
      if (preload_q) begin
        y_d[chan_q] = x_ext;
        y_out_d     = x_q;
      end else begin
        y_d[chan_q] = y_new;
        y_out_d     = bypass_q ? x_q : y_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      chan_q    <= '0;
      k_q       <= '0;
      bypass_q  <= 1'b0;
      preload_q <= 1'b0;
      acc_q     <= 1'b0;
      xp_q      <= '{default: INIT_ST};
      y_q       <= '{default: INIT_ST};
      y_out_q   <= INIT;
      y_valid_q <= 1'b0;
      y_chan_q  <= '0;
    end else begin
      x_q       <= x_d;
      chan_q    <= chan_d;
      k_q       <= k_d;
      bypass_q  <= bypass_d;
      preload_q <= preload_d;
      acc_q     <= acc_d;
      xp_q      <= xp_d;
      y_q       <= y_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      y_chan_q  <= y_chan_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign y_chan  = y_chan_q;

endmodule
